// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes and FSM state types for the AXI-Lite register file
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP}  wr_state_e;
  typedef enum logic {R_IDLE, R_VALID} rd_state_e;

endpackage

// File: rtl/seg7_hex_dec.sv
// rtl/seg7_hex_dec.sv - hex nibble to active-low seven-segment pattern, dp in bit 0
module seg7_hex_dec (
  input  logic [3:0] i_nibble,
  input  logic       i_dp_en,
  output logic [7:0] o_pattern
);

  logic [7:0] w_glyph;

  always_comb begin
    w_glyph = 8'hFF;
    case (i_nibble)
      4'h0: w_glyph = 8'h03;
      4'h1: w_glyph = 8'h9F;
      4'h2: w_glyph = 8'h25;
      4'h3: w_glyph = 8'h0D;
      4'h4: w_glyph = 8'h99;
      4'h5: w_glyph = 8'h49;
      4'h6: w_glyph = 8'h41;
      4'h7: w_glyph = 8'h1F;
      4'h8: w_glyph = 8'h01;
      4'h9: w_glyph = 8'h09;
      4'hA: w_glyph = 8'h11;
      4'hB: w_glyph = 8'hC1;
      4'hC: w_glyph = 8'h63;
      4'hD: w_glyph = 8'h85;
      4'hE: w_glyph = 8'h61;
      4'hF: w_glyph = 8'h71;
      default: w_glyph = 8'hFF;
    endcase
  end

  assign o_pattern = {w_glyph[7:1], ~i_dp_en};

endmodule

// File: rtl/axi_lite_regfile_disp.sv
// rtl/axi_lite_regfile_disp.sv - AXI-Lite register file slave with hex readback on a 7-segment digit
module axi_lite_regfile_disp
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic [7:0]        disp_hex
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  wr_state_e         r_wstate, w_wstate_nxt;
  logic              r_aw_got, r_w_got;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_bresp;
  logic              w_awready, w_wready, w_commit;
  logic              w_aw_hs, w_w_hs;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdat;
  logic              w_waddr_ok;

  rd_state_e         r_rstate, w_rstate_nxt;
  logic              w_arready, w_ar_hs, w_r_hs, w_araddr_ok;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic [7:0]        r_disp;
  logic [7:0]        w_seg;
  logic              w_dp_en;

  // Address/data come from the latch if that half already completed, else straight from the bus.
  assign w_waddr     = r_aw_got ? r_awaddr : s_awaddr;
  assign w_wdat      = r_w_got  ? r_wdata  : s_wdata;
  assign w_waddr_ok  = 32'(w_waddr)  < DEPTH;
  assign w_araddr_ok = 32'(s_araddr) < DEPTH;
  assign w_aw_hs     = s_awvalid && w_awready;
  assign w_w_hs      = s_wvalid && w_wready;

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = !r_aw_got;
        w_wready  = !r_w_got;
        if ((r_aw_got || s_awvalid) && (r_w_got || s_wvalid)) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: if (s_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate <= W_IDLE;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_bresp  <= RESP_OKAY;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= DATA_W'(i);
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) begin
        r_aw_got <= 1'b1;
        r_awaddr <= s_awaddr;
      end
      if (w_w_hs) begin
        r_w_got <= 1'b1;
        r_wdata <= s_wdata;
      end
      if (w_commit) begin
        r_bresp <= w_waddr_ok ? RESP_OKAY : RESP_SLVERR;
        if (w_waddr_ok) r_mem[w_waddr] <= w_wdat;
      end
      if (r_wstate == W_RESP && s_bready) begin
        r_aw_got <= 1'b0;
        r_w_got  <= 1'b0;
      end
    end
  end

  assign w_ar_hs = s_arvalid && w_arready;
  assign w_r_hs  = (r_rstate == R_VALID) && s_rready;

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_arready    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = 1'b1;
        if (s_arvalid) w_rstate_nxt = R_VALID;
      end
      R_VALID: if (s_rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  generate
    if (DATA_W > 4) begin : g_dp_upper
      assign w_dp_en = |r_rdata[DATA_W-1:4];
    end else begin : g_dp_none
      assign w_dp_en = 1'b0;
    end
  endgenerate

  seg7_hex_dec u_seg (
    .i_nibble  (r_rdata[3:0]),
    .i_dp_en   (w_dp_en),
    .o_pattern (w_seg)
  );

  // Same-edge write commit and AR sample r_mem before the NBA update, so the old value is returned.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_disp   <= 8'hFF;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_araddr_ok ? r_mem[s_araddr] : '0;
        r_rresp <= w_araddr_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (w_r_hs) r_disp <= (r_rresp == RESP_SLVERR) ? 8'hFE : w_seg;
    end
  end

  assign s_awready = w_awready;
  assign s_wready  = w_wready;
  assign s_bvalid  = (r_wstate == W_RESP);
  assign s_bresp   = r_bresp;
  assign s_arready = w_arready;
  assign s_rvalid  = (r_rstate == R_VALID);
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;
  assign disp_hex  = r_disp;

endmodule

// File: tb/tb_axi_lite_regfile_disp.sv
// tb/tb_axi_lite_regfile_disp.sv - directed plus random bench for axi_lite_regfile_disp
module tb_axi_lite_regfile_disp;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              s_awvalid, s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_wvalid, s_wready;
  logic [DATA_W-1:0] s_wdata;
  logic              s_bvalid, s_bready;
  logic [1:0]        s_bresp;
  logic              s_arvalid, s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_rvalid, s_rready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic [7:0]        disp_hex;

  int checks   = 0;
  int failures = 0;

  logic [7:0] glyph [16];
  logic [7:0] ref_mem [16];

  axi_lite_regfile_disp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_awaddr  (s_awaddr),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_wdata   (s_wdata),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_bresp   (s_bresp),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_araddr  (s_araddr),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .disp_hex  (disp_hex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = (i < DEPTH) ? 8'(i) : 8'h00;
  endtask

  function automatic logic [7:0] exp_disp(input logic [7:0] d, input logic err);
    logic [7:0] g;
    if (err) return 8'hFE;
    g = glyph[d[3:0]];
    return (d[7:4] != 4'h0) ? (g & 8'hFE) : g;
  endfunction

  // mode 0: AW and W together; 1: W first; 2: AW first. gap = idle cycles between halves.
  task automatic do_write(input logic [3:0] addr, input logic [7:0] data, input int mode,
                          input int gap, input int bhold);
    logic       ok;
    ok = (int'(addr) < DEPTH);
    s_awaddr = addr;
    s_wdata  = data;
    if (mode == 0) begin
      check("wr_ready_both", {30'd0, s_awready, s_wready}, 32'h3);
      s_awvalid = 1'b1; s_wvalid = 1'b1;
      step();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
    end else begin
      if (mode == 1) s_wvalid = 1'b1; else s_awvalid = 1'b1;
      step();
      s_wvalid = 1'b0; s_awvalid = 1'b0;
      check("wr_half_ready", {30'd0, s_awready, s_wready}, (mode == 1) ? 32'h2 : 32'h1);
      for (int i = 0; i < gap; i++) begin
        check("wr_no_b_early", {31'd0, s_bvalid}, 32'h0);
        step();
      end
      if (mode == 1) s_awvalid = 1'b1; else s_wvalid = 1'b1;
      step();
      s_wvalid = 1'b0; s_awvalid = 1'b0;
    end
    check("wr_bvalid", {31'd0, s_bvalid}, 32'h1);
    check("wr_bresp", {30'd0, s_bresp}, ok ? 32'h0 : 32'h2);
    if (ok) ref_mem[addr] = data;
    for (int i = 0; i < bhold; i++) begin
      step();
      check("wr_bhold", {29'd0, s_bvalid, s_awready, s_wready}, 32'h4);
    end
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    check("wr_b_done", {29'd0, s_bvalid, s_awready, s_wready}, 32'h3);
  endtask

  task automatic do_read(input logic [3:0] addr, input int rhold);
    logic       ok;
    logic [7:0] exp;
    ok  = (int'(addr) < DEPTH);
    exp = ok ? ref_mem[addr] : 8'h00;
    check("rd_arready", {31'd0, s_arready}, 32'h1);
    s_araddr = addr; s_arvalid = 1'b1;
    step();
    s_arvalid = 1'b0;
    check("rd_rvalid", {31'd0, s_rvalid}, 32'h1);
    check("rd_rdata", {24'd0, s_rdata}, {24'd0, exp});
    check("rd_rresp", {30'd0, s_rresp}, ok ? 32'h0 : 32'h2);
    for (int i = 0; i < rhold; i++) begin
      step();
      check("rd_hold", {22'd0, s_rvalid, s_arready, s_rdata}, {22'd0, 2'b10, exp});
    end
    s_rready = 1'b1;
    step();
    s_rready = 1'b0;
    check("rd_r_done", {31'd0, s_rvalid}, 32'h0);
    check("rd_disp", {24'd0, disp_hex}, {24'd0, exp_disp(exp, !ok)});
  endtask

  initial begin
    glyph = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    model_reset();
    reset = 1'b1;
    s_awvalid = 0; s_awaddr = 0; s_wvalid = 0; s_wdata = 0; s_bready = 0;
    s_arvalid = 0; s_araddr = 0; s_rready = 0;
    step(); step();
    reset = 1'b0;
    step();

    check("rst_valids", {30'd0, s_bvalid, s_rvalid}, 32'h0);
    check("rst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'h7);
    check("rst_disp", {24'd0, disp_hex}, 32'hFF);
    check("rst_rdata", {22'd0, s_bresp, s_rdata}, 32'h0);

    do_read(4'd5, 0);
    check("tp_disp5", {24'd0, disp_hex}, 32'h49);

    do_write(4'd2, 8'h3C, 1, 1, 0);
    do_read(4'd2, 0);
    check("tp_disp3c", {24'd0, disp_hex}, 32'h62);

    do_write(4'd14, 8'hAA, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i < DEPTH) begin
        do_read(4'(i), 0);
      end
    end
    do_read(4'd14, 0);
    check("tp_disp_err", {24'd0, disp_hex}, 32'hFE);

    do_read(4'd9, 5);
    do_write(4'd4, 8'h81, 2, 2, 4);
    do_read(4'd4, 0);

    // Same-edge commit and AR: read sees the old contents.
    s_awaddr = 4'd7; s_wdata = 8'h0A; s_araddr = 4'd7;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
    step();
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    check("same_edge_rdata", {24'd0, s_rdata}, {24'd0, ref_mem[7]});
    check("same_edge_valids", {30'd0, s_bvalid, s_rvalid}, 32'h3);
    ref_mem[7] = 8'h0A;
    s_bready = 1; s_rready = 1;
    step();
    s_bready = 0; s_rready = 0;
    do_read(4'd7, 0);
    check("tp_disp0a", {24'd0, disp_hex}, 32'h11);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0)
        do_write(a, 8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 2)));
      else
        do_read(a, int'($urandom_range(0, 2)));
    end

    // Reset while bvalid is held and an AR is pending.
    do_read(4'd3, 0);
    s_awaddr = 4'd3; s_wdata = 8'h55; s_awvalid = 1; s_wvalid = 1;
    step();
    s_awvalid = 0; s_wvalid = 0;
    check("pre_rst_bvalid", {31'd0, s_bvalid}, 32'h1);
    s_araddr = 4'd6; s_arvalid = 1; reset = 1;
    step();
    reset = 0; s_arvalid = 0;
    model_reset();
    check("mid_rst_valids", {30'd0, s_bvalid, s_rvalid}, 32'h0);
    check("mid_rst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'h7);
    check("mid_rst_disp", {24'd0, disp_hex}, 32'hFF);
    do_read(4'd3, 0);
    do_read(4'd6, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile_disp.md
# axi_lite_regfile_disp

Parametrised AXI4-Lite slave register file with a seven-segment readback display. It is the successor of the single-channel display slave and sits between the board-level AXI-Lite master and the on-board 7-segment digit. Its additions are full five-channel handshakes, write response, out-of-range error signalling, and configurable width and depth. Every completed read updates the display with the hex digit of the data read.

## Interface
Parameters:
- ADDR_W, 4: address width in words (no byte addressing).
- DATA_W, 8: register width; must be ≥ 4.
- DEPTH, 16: number of registers; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_awvalid  in  1 / s_awready  out  1 / s_awaddr  in  ADDR_W: write address channel.
- s_wvalid  in  1 / s_wready  out  1 / s_wdata  in  DATA_W: write data channel.
- s_bvalid  out  1 / s_bready  in  1 / s_bresp  out  2: write response channel.
- s_arvalid  in  1 / s_arready  out  1 / s_araddr  in  ADDR_W: read address channel.
- s_rvalid  out  1 / s_rready  in  1 / s_rdata  out  DATA_W / s_rresp  out  2: read data channel.
- disp_hex  out  8: [7:1] = segments a..g, active low; [0] = decimal point, active low.

## Operation
- Reset:
  - register i is loaded with i (truncated to DATA_W);
  - both FSMs go to IDLE;
  - s_bvalid = s_rvalid = 0, s_bresp = s_rresp = 2'b00, s_rdata = 0;
  - s_awready = s_wready = s_arready = 1 (they are combinational from IDLE state);
  - disp_hex = 8'hFF (blank).
- Write FSM, states W_IDLE and W_RESP:
  - In W_IDLE, flags aw_got and w_got record which handshakes are done. s_awready = !aw_got and s_wready = !w_got.
  - AW and W may complete in either order or in the same cycle. The address and data are latched at their own handshakes.
  - On the edge where the second handshake completes (or both complete together):
    - if addr < DEPTH, the register is written and the response is OKAY (2'b00);
    - otherwise nothing is written and the response is SLVERR (2'b10);
    - the FSM moves to W_RESP with s_bvalid = 1.
  - In W_RESP, s_awready = s_wready = 0. s_bvalid and s_bresp are held until s_bready.
  - The B handshake clears the flags and returns the FSM to W_IDLE.
- Read FSM, states R_IDLE and R_VALID:
  - In R_IDLE, s_arready = 1.
  - At the AR handshake edge:
    - s_rdata = reg[araddr] and s_rresp = OKAY, or s_rdata = 0 and s_rresp = SLVERR when out of range;
    - s_rvalid = 1 and the FSM moves to R_VALID.
  - In R_VALID, s_arready = 0 and s_rdata/s_rresp are held stable until s_rready.
  - The R handshake returns the FSM to R_IDLE and updates disp_hex.
- Display update, on each R handshake:
  - if s_rresp = SLVERR: disp_hex = 8'hFE (blank digit, dp lit);
  - otherwise the segments show the hex glyph of s_rdata[3:0] (0-F), and dp is lit iff s_rdata[DATA_W-1:4] != 0.
  - Glyphs 0-9 (active-low a..g,dp): 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09. Glyphs A-F: A=11, b=C1, C=63, d=85, E=61, F=71.
- The read and write FSMs are fully independent and may be active in the same cycle.

## Timing
- Write: bvalid rises 1 cycle after the last of the AW/W handshakes. Minimum write period is 2 cycles (handshake, then B with bready already high).
- Read: rvalid rises 1 cycle after the AR handshake. Minimum read period is 2 cycles. disp_hex changes 1 cycle after the R handshake.
- Write commit and AR handshake to the same address on the same edge: the read returns the old value.
- A read issued on the cycle after the commit edge returns the new value.
- Backpressure: while bvalid or rvalid is stuck, no further AW/W or AR handshakes are accepted on that side.
- Reset asserted mid-transaction:
  - all in-flight state is discarded and registers are restored to their init values;
  - valids drop on the next edge;
  - no partial write survives.

## Structure
- Shared package axi_lite_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the write FSM state enum (W_IDLE, W_RESP) and the read FSM state enum (R_IDLE, R_VALID).
- One sub-module, seg7_hex_dec: 4-bit nibble plus dp-enable in, 8-bit active-low pattern out. It is purely combinational and is used on the display path.

## Test plan
- Reset, then read addr 5 with rready held high → rvalid 1 cycle after AR, rdata=5, rresp=00, disp_hex=8'h49.
- W handshake with data 8'h3C, then AW handshake 2 cycles later to addr 2; bready=1 → bvalid 1 cycle after AW, bresp=00. A following read of addr 2 gives rdata=3C and disp_hex=8'h62 (C with dp lit).
- DEPTH=12: write to addr 14 → bresp=10 and no register changes. Read addr 14 → rresp=10, rdata=0, disp_hex=8'hFE.
- Hold rready low for 5 cycles after rvalid → rdata stable and arready=0 throughout. Hold bready low → awready=wready=0 and bvalid held.
- Same-edge write of 8'h0A to addr 7 and AR to addr 7 → rdata=7. The next read of addr 7 → rdata=0A, disp_hex=8'h11.
- Assert reset while bvalid=1 and an AR is pending → next cycle all valids are 0, readies are 1, and reg[addr] is back to its index value.
